trg_spi_cmd_rx: RTL

SPI slave front end that feeds the trigger-pulse generator. Oversamples the external spi_clk/spi_cs/spi_mosi pins in the system clock domain, deserializes 16-bit command frames, and delivers them through a 4-entry FIFO on a valid/ready interface. The trigger-pulse stage consumes these frames directly.

---
 rtl/trg_spi_cmd_rx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/trg_spi_cmd_rx.sv
// trg_spi_cmd_rx: oversampled SPI slave that turns 16-bit command frames into FIFO entries.
// Optional odd parity bit per frame is enabled by defining TRG_SPI_PARITY_EN.
module trg_spi_cmd_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             spi_clk,
  input  logic             spi_cs,
  input  logic             spi_mosi,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [3:0]       cmd_code,
  output logic [11:0]      cmd_data,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_cnt,
  output logic             ovf,
  output logic             busy
);

`ifdef TRG_SPI_PARITY_EN
  localparam int FW = 17;
`else
  localparam int FW = 16;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  logic [2:0]       sclk_q;
  logic [2:0]       scs_q;
  logic [1:0]       smosi_q;
  logic             clk_rise_q;
  logic             cs_rise_q;
  logic             cs_fall_q;
  logic [1:0]       settle_q;
  logic             armed_q;
  state_t           state_q;
  logic [FW-1:0]    sr_q;
  logic [4:0]       cnt_q;
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [ERR_W-1:0] err_q;
  logic             ovf_q;

  logic        frame_ok;
  logic [15:0] payload;
  logic        push_req;
  logic        bad_req;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [15:0] head;

`ifdef TRG_SPI_PARITY_EN
  assign frame_ok = (cnt_q == 5'd17) && (^sr_q);
  assign payload  = sr_q[16:1];
`else
  assign frame_ok = (cnt_q == 5'd16);
  assign payload  = sr_q;
`endif

  assign push_req = (state_q == CHECK) && frame_ok;
  assign bad_req  = (state_q == CHECK) && !frame_ok;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && cmd_ready;
  assign push  = push_req && (!full || pop);
  assign head  = mem_q[rptr_q[AW-1:0]];

  assign cmd_valid = !empty;
  assign cmd_code  = head[15:12];
  assign cmd_data  = head[11:0];
  assign err_cnt   = err_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q == SHIFT);

  // Two-stage synchronizers plus registered edge pulses.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      sclk_q     <= '0;
      scs_q      <= '1;
      smosi_q    <= '0;
      clk_rise_q <= 1'b0;
      cs_rise_q  <= 1'b0;
      cs_fall_q  <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[1:0], spi_clk};
      scs_q      <= {scs_q[1:0], spi_cs};
      smosi_q    <= {smosi_q[0], spi_mosi};
      clk_rise_q <= sclk_q[1] && !sclk_q[2];
      cs_rise_q  <= scs_q[1] && !scs_q[2];
      cs_fall_q  <= !scs_q[1] && scs_q[2];
    end
  end

  // Frame FSM; a fall seen before cs was observed high after reset is ignored.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != 2'd3) begin
        settle_q <= settle_q + 2'd1;
      end else if (scs_q[2]) begin
        armed_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (cs_fall_q && armed_q) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (clk_rise_q) begin
            sr_q <= {sr_q[FW-2:0], smosi_q[1]};
            if (cnt_q != 5'd31) begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
          if (cs_rise_q) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Command FIFO with wrap-bit pointers.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= payload;
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end

  // Error counter and overflow flag; clear wins over a same-cycle update.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      err_q <= '0;
      ovf_q <= 1'b0;
    end else if (err_clr) begin
      err_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (bad_req && (err_q != '1)) begin
        err_q <= err_q + ERR_W'(1);
      end
      if (push_req && full && !pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

endmodule
